gpio_in_conditioner: RTL and testbench
======================================

Name: gpio_in_conditioner

Overview:
- Sits directly downstream of the input pad cells. Consumes the raw pad-side data (the pad's Y outputs) before the signals enter the FPGA fabric routing.
- Per bit, it synchronises the asynchronous pad level into the `clk` domain and optionally debounces it.
- It then produces a clean level plus one-cycle rise and fall pulses for fabric logic.

Parameters:
- WIDTH, 8, number of pad bits conditioned in parallel (>=1).
- SYNC_STAGES, 2, synchroniser flop depth (>=2).
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new level must persist before it is accepted (>=1).

Ports:
- clk  input  1  fabric clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- pad_in  input  WIDTH  raw pad data from the input pads; asynchronous to clk.
- filter_en  input  1  1 = debounce active; 0 = bypass (accept any change after one synchronised cycle).
- data_out  output  WIDTH  conditioned level.
- rise  output  WIDTH  one-cycle pulse when data_out bit goes 0->1.
- fall  output  WIDTH  one-cycle pulse when data_out bit goes 1->0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is `clk`, reset port is `reset`. All state updates on the rising edge of `clk`.
- Reset (reset=1 at an edge): all sync flops, counters, data_out, rise and fall are cleared to 0. Reset wins over every other condition.
- No pulse on reset release. If the pad is already high, data_out rises through the normal path after the full latency, and rise pulses then.
- Synchroniser, per bit: a chain of SYNC_STAGES flops. sync_q is the last stage. Nothing downstream samples pad_in directly.
- Debounce counter, per bit: width clog2(DEBOUNCE_CYCLES), minimum 1 bit. At each edge, priority order:
  1. sync_q == data_out: cnt <= 0.
  2. sync_q != data_out and (cnt == DEBOUNCE_CYCLES-1 or filter_en == 0): data_out <= sync_q, cnt <= 0.
  3. Otherwise: cnt <= cnt + 1.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Glitch rejection: any excursion of sync_q lasting fewer than DEBOUNCE_CYCLES cycles returns the counter to 0. data_out, rise and fall are untouched.
- Latency, filter_en=1: pad_in changes before edge E and stays stable. data_out updates at edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1 (defaults: the 6th edge counting E as 1st).
- Latency, filter_en=0: data_out updates at edge E+SYNC_STAGES (defaults: the 3rd edge).
- rise/fall are registered. They are asserted during exactly the cycle after the edge at which data_out changes, i.e. coincident with the new data_out value. They are never both high for the same bit.
- filter_en toggled mid-count:
  - 1->0: a pending difference is accepted at the next edge.
  - 0->1: a difference in flight continues counting from the current cnt.
  - filter_en is a static config bit in normal use but must be glitch-safe at any time.
- Bits are fully independent. Simultaneous events on different bits produce simultaneous pulses.
- Reset asserted mid-count discards the count. No pulse is produced on the reset edge.

Decomposition:
- No shared package needed. The counter width function (clog2, min 1) goes in the codebase's common include as a constant function.
- One natural sub-module: gpio_in_bit_filter (single-bit synchroniser + debounce + edge pulse, same parameters minus WIDTH). gpio_in_conditioner instantiates it WIDTH times via generate.
- Expected size ~150-200 lines total.

Test Plan (defaults WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated):
- Reset, then pad_in=0xFF held with filter_en=1 -> data_out=0x00 through edge 5 after release; data_out=0xFF and rise=0xFF on edge 6; rise=0x00 the next cycle; fall never set.
- filter_en=1, pad_in[0] pulses high for 3 clk cycles (synchronous stimulus) -> data_out[0], rise[0], fall[0] stay 0. A 4-cycle pulse -> data_out[0]=1 for exactly 4 cycles, with one rise[0] pulse and one fall[0] pulse.
- filter_en=0, pad_in[3] 0->1 -> data_out[3]=1 and rise[3]=1 on the 3rd edge. A 1-cycle pad pulse -> data_out[3] high for exactly 1 cycle.
- Mid-count reset: pad_in=0x01, reset asserted for one edge after 4 edges -> outputs 0 with no pulse during reset. After release the full 6-edge latency restarts.
- filter_en 1->0 while bit 5 counter=2 -> data_out[5] updates on the next edge, with a single rise[5].
- Independent bits: pad_in[1] rises and pad_in[6] falls (from 1) on the same cycle -> rise=0x02 and fall=0x40 in the same cycle.

Source files
------------

// File: rtl/gpio_in_conditioner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_in_conditioner_pkg
// Shared constant helpers for the GPIO input conditioner.
// Revision: 1.0
// ---------------------------------------------------------------------------
package gpio_in_conditioner_pkg;

  // Debounce counter width: clog2 of the cycle count, never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_in_bit_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_in_bit_filter
// Single-bit pad synchroniser, optional debounce and registered edge pulses.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gpio_in_bit_filter
  import gpio_in_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  input  logic filter_en,
  output logic data,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic [CNT_W-1:0]       cnt;
  logic                   level;
  logic                   rise_ff;
  logic                   fall_ff;
  logic                   sync_q;
  logic                   differ;
  logic                   accept;

  assign sync_q = sync_ff[SYNC_STAGES-1];
  assign differ = sync_q != level;
  // Bypass ignores the count, so clearing filter_en mid-count accepts at once.
  assign accept = differ && ((cnt == CNT_MAX) || !filter_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      rise_ff <= 1'b0;
      fall_ff <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], pad};
      rise_ff <= accept && sync_q;
      fall_ff <= accept && !sync_q;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_q;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data = level;
  assign rise = rise_ff;
  assign fall = fall_ff;

endmodule
`default_nettype wire

// File: rtl/gpio_in_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_in_conditioner
// WIDTH independent pad-input conditioners: sync, debounce, rise/fall pulses.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gpio_in_conditioner
  import gpio_in_conditioner_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  input  logic             filter_en,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    gpio_in_bit_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk      (clk),
      .reset    (reset),
      .pad      (pad_in[b]),
      .filter_en(filter_en),
      .data     (data_out[b]),
      .rise     (rise[b]),
      .fall     (fall[b])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gpio_in_conditioner
// Vector table, directed corner sequences and random run against a model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_gpio_in_conditioner;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pad_in;
  logic         filter_en;
  logic [W-1:0] data_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int checks = 0;
  int errors = 0;

  gpio_in_conditioner #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .pad_in(pad_in), .filter_en(filter_en),
    .data_out(data_out), .rise(rise), .fall(fall)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the synchronised pad has
  // disagreed with it for DEB consecutive edges (or at once when unfiltered).
  logic [W-1:0] hist [S];
  logic [W-1:0] m_out  = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  int           run [W];

  function automatic void model_edge(input logic r, input logic f, input logic [W-1:0] p);
    logic [W-1:0] synced;
    if (r) begin
      for (int i = 0; i < S; i++) hist[i] = '0;
      for (int b = 0; b < W; b++) run[b] = 0;
      m_out = '0; m_rise = '0; m_fall = '0;
      return;
    end
    synced = hist[S-1];
    m_rise = '0; m_fall = '0;
    for (int b = 0; b < W; b++) begin
      if (synced[b] == m_out[b]) run[b] = 0;
      else begin
        run[b] = run[b] + 1;
        if (run[b] >= DEB || !f) begin
          m_out[b] = synced[b];
          if (synced[b]) m_rise[b] = 1'b1; else m_fall[b] = 1'b1;
          run[b] = 0;
        end
      end
    end
    for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = p;
  endfunction

  task automatic step(input logic r, input logic f, input logic [W-1:0] p);
    reset = r; filter_en = f; pad_in = p;
    model_edge(r, f, p);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx, input logic [W-1:0] d,
                           input logic [W-1:0] r, input logic [W-1:0] f);
    check({name, "_data"}, idx, data_out, d);
    check({name, "_rise"}, idx, rise, r);
    check({name, "_fall"}, idx, fall, f);
  endtask

  typedef struct {
    logic         rst;
    logic         fen;
    logic [W-1:0] pad;
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [W-1:0] f;
  } vec_t;
  vec_t tbl[$];

  function automatic void push(input logic rs, input logic fe, input logic [W-1:0] p,
                               input logic [W-1:0] d, input logic [W-1:0] r,
                               input logic [W-1:0] f);
    vec_t v;
    v.rst = rs; v.fen = fe; v.pad = p; v.d = d; v.r = r; v.f = f;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p;
    logic         f;
    logic         r;
    int           waited;

    reset = 1'b1; filter_en = 1'b1; pad_in = '0;

    // Filtered rise of all bits: six edges after reset release.
    push(1, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) push(0, 1, 8'hFF, 8'h00, 8'h00, 8'h00);
    push(0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    push(0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    push(0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    // 3-cycle glitch on bit 0 is rejected.
    push(1, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) push(0, 1, 8'h01, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) push(0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    // 4-cycle pulse on bit 0 passes as a 4-cycle level.
    for (int i = 0; i < 4; i++) push(0, 1, 8'h01, 8'h00, 8'h00, 8'h00);
    push(0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    push(0, 1, 8'h00, 8'h01, 8'h01, 8'h00);
    for (int i = 0; i < 3; i++) push(0, 1, 8'h00, 8'h01, 8'h00, 8'h00);
    push(0, 1, 8'h00, 8'h00, 8'h00, 8'h01);
    push(0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    // Bypass: bit 3 accepted on the third edge; 1-cycle pulse stays 1 cycle.
    push(1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    push(0, 0, 8'h08, 8'h00, 8'h00, 8'h00);
    push(0, 0, 8'h08, 8'h00, 8'h00, 8'h00);
    push(0, 0, 8'h08, 8'h08, 8'h08, 8'h00);
    push(0, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    push(1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    push(0, 0, 8'h08, 8'h00, 8'h00, 8'h00);
    push(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    push(0, 0, 8'h00, 8'h08, 8'h08, 8'h00);
    push(0, 0, 8'h00, 8'h00, 8'h00, 8'h08);
    push(0, 0, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].fen, tbl[i].pad);
      check_all("tbl", i, tbl[i].d, tbl[i].r, tbl[i].f);
    end

    // Mid-count reset discards progress; full latency restarts on release.
    step(1, 1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h01);
      check_all("midrst_pre", i, 8'h00, 8'h00, 8'h00);
    end
    step(1, 1, 8'h01);
    check_all("midrst_rst", 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h01);
      check_all("midrst_wait", i, 8'h00, 8'h00, 8'h00);
    end
    step(0, 1, 8'h01);
    check_all("midrst_acc", 0, 8'h01, 8'h01, 8'h00);

    // filter_en dropped while bit 5 has counted to 2.
    step(1, 1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h20);
      check_all("fen_pre", i, 8'h00, 8'h00, 8'h00);
    end
    step(0, 0, 8'h20);
    check_all("fen_acc", 0, 8'h20, 8'h20, 8'h00);
    step(0, 0, 8'h20);
    check_all("fen_post", 0, 8'h20, 8'h00, 8'h00);

    // Simultaneous rise on bit 1 and fall on bit 6.
    step(1, 1, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 1, 8'h40);
    check_all("indep_init", 0, 8'h40, 8'h40, 8'h00);
    waited = 0;
    do begin
      step(0, 1, 8'h02);
      waited++;
    end while (rise == 8'h00 && fall == 8'h00 && waited < 12);
    check("indep_latency", 0, 8'(waited), 8'd6);
    check_all("indep_evt", 0, 8'h02, 8'h02, 8'h40);

    // Random pad activity against the model, including filter and reset churn.
    p = '0; f = 1'b1;
    step(1, f, p);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) p[b] = ~p[b];
      if ($urandom_range(0, 39) == 0) f = ~f;
      r = ($urandom_range(0, 199) == 0);
      step(r, f, p);
      check_all("rand", c, m_out, m_rise, m_fall);
      check("rand_both", c, rise & fall, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
